// File: rtl/pair_scan_ctrl.sv
// Serialises a parallel word MSB-first through a Moore pair detector and
// reports the adjacent-equal-pair count and a threshold hit over valid/ready.
module pair_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] thresh,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D_START, D_LAST0, D_LAST1, D_PAIR} det_t;

  state_t             state_q, state_d;
  det_t               det_q, det_d;
  logic               prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_hit_q, out_hit_d;

  logic               cur_bit;
  logic               pair_now;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      det_q       <= D_START;
      prev_q      <= 1'b0;
      idx_q       <= '0;
      shift_q     <= '0;
      thr_q       <= '0;
      cnt_q       <= '0;
      out_count_q <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
      out_hit_q   <= out_hit_d;
    end
  end

  // START never pairs, so the first bit of every word is excluded from counting.
  assign cur_bit  = shift_q[idx_q];
  assign pair_now = (det_q != D_START) && (cur_bit == prev_q);
  assign cnt_inc  = cnt_q + CNT_W'(pair_now);

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    thr_d       = thr_q;
    cnt_d       = cnt_q;
    out_count_d = out_count_q;
    out_hit_d   = out_hit_q;

    if (clr) begin
      state_d = IDLE;
      det_d   = D_START;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_d = in_data;
            thr_d   = thresh;
            cnt_d   = '0;
            det_d   = D_START;
            idx_d   = IDX_W'(WIDTH - 1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          prev_d = cur_bit;
          cnt_d  = cnt_inc;
          case (det_q)
            D_START: det_d = cur_bit ? D_LAST1 : D_LAST0;
            D_LAST0: det_d = cur_bit ? D_LAST1 : D_PAIR;
            D_LAST1: det_d = cur_bit ? D_PAIR  : D_LAST0;
            default: det_d = pair_now ? D_PAIR : (cur_bit ? D_LAST1 : D_LAST0);
          endcase
          if (idx_q == '0) begin
            state_d     = DONE;
            out_count_d = cnt_inc;
            out_hit_d   = (cnt_inc >= thr_q);
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign ser_bit   = ser_valid & cur_bit;
  assign out_valid = (state_q == DONE);
  assign out_count = out_count_q;
  assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Randomized and directed self-checking bench for pair_scan_ctrl against a
// word-level pair-count model.
module tb_pair_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] thresh;
  logic             ser_bit;
  logic             ser_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_hit;
  logic             out_valid;
  logic             out_ready;

  int compared   = 0;
  int mismatched = 0;

  pair_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .thresh(thresh), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .out_count(out_count), .out_hit(out_hit), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count positions where a bit equals its more-significant neighbour.
  function automatic int expCount(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = WIDTH - 1; i > 0; i--)
      if (w[i] == w[i-1]) n++;
    return n;
  endfunction

  task automatic waitIdle();
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Full transaction from IDLE with exact latency and serial-bit checks.
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] thr, input int hold);
    int exp_c;
    logic [CNT_W-1:0] held;
    exp_c = expCount(w);
    waitIdle();
    in_data  = w;
    thresh   = thr;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    thresh   = $urandom_range(0, 15);
    for (int k = 0; k < WIDTH; k++) begin
      checkOutput("ser_valid", {31'd0, ser_valid}, 32'd1);
      checkOutput("ser_bit", {31'd0, ser_bit}, {31'd0, w[WIDTH-1-k]});
      checkOutput("early_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("out_count", {28'd0, out_count}, exp_c);
    checkOutput("out_hit", {31'd0, out_hit}, (exp_c >= int'(thr)) ? 32'd1 : 32'd0);
    checkOutput("done_in_ready", {31'd0, in_ready}, 32'd0);
    held = out_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_count", {28'd0, out_count}, {28'd0, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("kept_count", {28'd0, out_count}, exp_c);
  endtask

  initial begin
    int accepts;
    int results[$];
    rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; thresh = '0; out_ready = 1'b0;
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    checkOutput("rst_count", {28'd0, out_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'b11001111, 4'd5, 0);
    applyStimulus(8'hAA, 4'd1, 1);
    applyStimulus(8'hFF, 4'd7, 0);
    applyStimulus(8'h00, 4'd8, 2);

    // Back-pressure with a competing word presented while in DONE.
    in_data = 8'b11001111; thresh = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    in_data = 8'hFF; in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_count", {28'd0, out_count}, 32'd5);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_not_taken", {31'd0, ser_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_new_taken", {31'd0, ser_valid}, 32'd1);
    repeat (WIDTH) @(negedge clk);
    checkOutput("bp_new_count", {28'd0, out_count}, 32'd7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort mid-scan, then a fresh word must not see stale history.
    in_data = 8'hFF; thresh = 4'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checkOutput("clr_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("clr_ser_valid", {31'd0, ser_valid}, 32'd0);
    for (int c = 0; c < WIDTH; c++) begin
      checkOutput("clr_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(8'b10011001, 4'd2, 0);

    // Back-to-back with in_valid and out_ready held high.
    accepts = 0;
    in_data = 8'hF0; thresh = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 2 * (WIDTH + 2) + 4; c++) begin
      if (out_valid) results.push_back(int'(out_count));
      if (in_valid && in_ready) begin
        accepts++;
        @(negedge clk);
        if (accepts == 1) in_data = 8'h0F;
        else in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_accepts", accepts, 32'd2);
    checkOutput("b2b_results", results.size(), 32'd2);
    if (results.size() == 2) begin
      checkOutput("b2b_first", results[0], expCount(8'hF0));
      checkOutput("b2b_second", results[1], expCount(8'h0F));
    end

    for (int r = 0; r < 40; r++)
      applyStimulus(WIDTH'($urandom), CNT_W'($urandom_range(0, WIDTH)), $urandom_range(0, 3));

    // Asynchronous reset in the middle of a scan.
    waitIdle();
    in_data = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_ser_valid", {31'd0, ser_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'hC3, 4'd4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
